// File: rtl/otp_ctrl_part_fill.sv
// otp_ctrl_part_fill
//
// Partition fill sequencer. On an accepted start it reads Depth consecutive
// 64-bit words from the OTP macro (starting at BaseAddr), writes each good word
// into the downstream register file at addresses 0..Depth-1 and accumulates an
// XOR digest of the words written. A read error aborts the fill and raises a
// sticky error flag.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   start_i             one-cycle start request (ignored unless idle)
//   busy_o, done_o      fill in progress / one-cycle success pulse
//   err_o               sticky read-error flag, cleared by reset or next start
//   otp_req_o/addr_o    OTP read request and word address
//   otp_gnt_i           OTP grant
//   otp_rvalid_i/rdata_i/err_i   OTP read response
//   wr_en_o/addr_o/data_o        register-file write port
//   digest_o            XOR of all words written in the current fill

module otp_ctrl_part_fill #(
    parameter int unsigned Depth    = 4,
    parameter logic [15:0] BaseAddr = 16'h0000,
    localparam int unsigned Aw      = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          otp_req_o,
    output logic [15:0]   otp_addr_o,
    input  logic          otp_gnt_i,
    input  logic          otp_rvalid_i,
    input  logic [63:0]   otp_rdata_i,
    input  logic          otp_err_i,
    output logic          wr_en_o,
    output logic [Aw-1:0] wr_addr_o,
    output logic [63:0]   wr_data_o,
    output logic [63:0]   digest_o
);

    localparam logic [Aw-1:0] LastCnt = Aw'(Depth - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [Aw-1:0] cnt_q;
    logic          wr_en_q;
    logic [Aw-1:0] wr_addr_q;
    logic [63:0]   wr_data_q;
    logic [63:0]   digest_q;
    logic          err_q;

    logic accept;
    logic good_rd;
    logic bad_rd;
    logic last_blk;

    assign accept   = (state_q == StIdle) && start_i;
    // Responses only count while a read is outstanding.
    assign good_rd  = (state_q == StWait) && otp_rvalid_i && !otp_err_i;
    assign bad_rd   = (state_q == StWait) && otp_rvalid_i && otp_err_i;
    assign last_blk = (cnt_q == LastCnt);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StReq;
            end
            StReq: begin
                if (otp_gnt_i) state_d = StWait;
            end
            StWait: begin
                if (good_rd) begin
                    state_d = last_blk ? StDone : StReq;
                end else if (bad_rd) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        otp_req_o  = 1'b0;
        otp_addr_o = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            StReq: begin
                otp_req_o  = 1'b1;
                // Address is only driven while requesting so idle/reset reads as zero.
                otp_addr_o = BaseAddr + 16'(cnt_q);
                busy_o     = 1'b1;
            end
            StWait: busy_o = 1'b1;
            StDone: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: block counter, write port, digest and error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            digest_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= good_rd;
            if (accept) begin
                cnt_q    <= '0;
                digest_q <= '0;
                err_q    <= 1'b0;
            end
            if (good_rd) begin
                wr_addr_q <= cnt_q;
                wr_data_q <= otp_rdata_i;
                digest_q  <= digest_q ^ otp_rdata_i;
                if (!last_blk) cnt_q <= cnt_q + Aw'(1);
            end
            // Partial digest is kept on error for diagnosis.
            if (bad_rd) err_q <= 1'b1;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign digest_o  = digest_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_otp_ctrl_part_fill.sv
module tb_otp_ctrl_part_fill;

    logic clk;
    logic rst;

    // Depth=4, BaseAddr=0x10 instance
    logic        start, gnt, rvalid, oerr;
    logic [63:0] rdata;
    logic        busy, done, err, req, wr_en;
    logic [15:0] addr;
    logic [1:0]  wr_addr;
    logic [63:0] wr_data, digest;

    // Depth=1, BaseAddr=0xFFFF instance
    logic        s_start, s_gnt, s_rvalid, s_oerr;
    logic [63:0] s_rdata;
    logic        s_busy, s_done, s_err, s_req, s_wr_en;
    logic [15:0] s_addr;
    logic [0:0]  s_wr_addr;
    logic [63:0] s_wr_data, s_digest;

    int total = 0;
    int bad   = 0;

    otp_ctrl_part_fill #(.Depth(4), .BaseAddr(16'h0010)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .otp_req_o(req), .otp_addr_o(addr), .otp_gnt_i(gnt),
        .otp_rvalid_i(rvalid), .otp_rdata_i(rdata), .otp_err_i(oerr),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .digest_o(digest)
    );

    otp_ctrl_part_fill #(.Depth(1), .BaseAddr(16'hFFFF)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
        .err_o(s_err), .otp_req_o(s_req), .otp_addr_o(s_addr), .otp_gnt_i(s_gnt),
        .otp_rvalid_i(s_rvalid), .otp_rdata_i(s_rdata), .otp_err_i(s_oerr),
        .wr_en_o(s_wr_en), .wr_addr_o(s_wr_addr), .wr_data_o(s_wr_data),
        .digest_o(s_digest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        gnt;
        logic        rvalid;
        logic        oerr;
        logic [63:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_busy;
        logic        e_done;
        logic        e_wr_en;
        logic [1:0]  e_wr_addr;
        logic [63:0] e_wr_data;
        logic [63:0] e_digest;
        logic        e_err;
    } vec_t;

    vec_t vecs[11];
    logic [63:0] words[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Zero-wait OTP responder for the Depth=4 instance with optional grant stall,
    // error injection, a second start pulse and a reset pulse. Cycle 0 is the
    // start cycle; outputs are observed then inputs driven on each falling edge.
    task automatic run4(input int stall_blk, input int stall_n, input int err_blk,
                        input int restart_cyc, input int rst_cyc,
                        output int done_cyc, output int nwr);
        int  blk   = 0;
        int  stall = 0;
        bit  pend  = 0;
        done_cyc = -1;
        nwr      = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_en) begin
                chk($sformatf("wr_addr[%0d]", nwr), 64'(wr_addr), 64'(nwr));
                chk($sformatf("wr_data[%0d]", nwr), wr_data, words[nwr & 3]);
                nwr++;
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (c == 1) chk("err_cleared_by_start", 64'(err), 64'd0);
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                chk("rst_req", 64'(req), 64'd0);
                chk("rst_addr", 64'(addr), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_wr_en", 64'(wr_en), 64'd0);
                chk("rst_wr_addr", 64'(wr_addr), 64'd0);
                chk("rst_wr_data", wr_data, 64'd0);
                chk("rst_digest", digest, 64'd0);
            end
            start  = (c == 0) || (c == restart_cyc);
            rst    = (c == rst_cyc);
            gnt    = 1'b0;
            rvalid = 1'b0;
            oerr   = 1'b0;
            rdata  = '0;
            if (pend) begin
                rvalid = 1'b1;
                rdata  = words[blk & 3];
                oerr   = (blk == err_blk);
                pend   = 0;
                blk++;
            end else if (req) begin
                chk($sformatf("req_addr_blk%0d", blk), 64'(addr), 64'(16'h0010 + blk));
                if (blk == stall_blk && stall < stall_n) begin
                    stall++;
                end else begin
                    gnt  = 1'b1;
                    pend = 1;
                end
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    int dc, nw;

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        {start, gnt, rvalid, oerr} = '0;
        rdata = '0;
        {s_start, s_gnt, s_rvalid, s_oerr} = '0;
        s_rdata = '0;
        words[0] = 64'd1; words[1] = 64'd2; words[2] = 64'd4; words[3] = 64'd8;

        //            st gn rv er rdata | req addr     bsy dn  we wa   wdata   digest  err
        vecs[0]  = '{1, 0, 0, 0, 64'd0, 0, 16'h0000, 0, 0, 0, 2'd0, 64'd0, 64'h0, 0};
        vecs[1]  = '{0, 1, 0, 0, 64'd0, 1, 16'h0010, 1, 0, 0, 2'd0, 64'd0, 64'h0, 0};
        vecs[2]  = '{0, 0, 1, 0, 64'd1, 0, 16'h0000, 1, 0, 0, 2'd0, 64'd0, 64'h0, 0};
        vecs[3]  = '{0, 1, 0, 0, 64'd0, 1, 16'h0011, 1, 0, 1, 2'd0, 64'd1, 64'h1, 0};
        vecs[4]  = '{0, 0, 1, 0, 64'd2, 0, 16'h0000, 1, 0, 0, 2'd0, 64'd1, 64'h1, 0};
        vecs[5]  = '{0, 1, 0, 0, 64'd0, 1, 16'h0012, 1, 0, 1, 2'd1, 64'd2, 64'h3, 0};
        vecs[6]  = '{0, 0, 1, 0, 64'd4, 0, 16'h0000, 1, 0, 0, 2'd1, 64'd2, 64'h3, 0};
        vecs[7]  = '{0, 1, 0, 0, 64'd0, 1, 16'h0013, 1, 0, 1, 2'd2, 64'd4, 64'h7, 0};
        vecs[8]  = '{0, 0, 1, 0, 64'd8, 0, 16'h0000, 1, 0, 0, 2'd2, 64'd4, 64'h7, 0};
        vecs[9]  = '{0, 0, 0, 0, 64'd0, 0, 16'h0000, 1, 1, 1, 2'd3, 64'd8, 64'hF, 0};
        vecs[10] = '{0, 0, 0, 0, 64'd0, 0, 16'h0000, 0, 0, 0, 2'd3, 64'd8, 64'hF, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_req", 64'(req), 64'd0);
        chk("reset_addr", 64'(addr), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_digest", digest, 64'd0);
        chk("reset_wr_data", wr_data, 64'd0);
        chk("reset_s_addr", 64'(s_addr), 64'd0);
        rst = 1'b0;

        // Zero-wait Depth=4 fill, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 64'(req), 64'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), 64'(addr), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].e_done));
            chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(vecs[i].e_wr_en));
            chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].e_wr_addr));
            chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wr_data);
            chk($sformatf("v%0d_digest", i), digest, vecs[i].e_digest);
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
            start  = vecs[i].start;
            gnt    = vecs[i].gnt;
            rvalid = vecs[i].rvalid;
            oerr   = vecs[i].oerr;
            rdata  = vecs[i].rdata;
        end

        // Grant withheld 3 cycles on block 2
        run4(2, 3, -1, -1, -1, dc, nw);
        chk("stall_done_cycle", 64'(dc), 64'd12);
        chk("stall_nwr", 64'(nw), 64'd4);
        chk("stall_digest", digest, 64'hF);

        // Read error on block 1
        run4(-1, 0, 1, -1, -1, dc, nw);
        chk("errrun_nwr", 64'(nw), 64'd1);
        chk("errrun_no_done", 64'(dc), -64'sd1);
        chk("errrun_err", 64'(err), 64'd1);
        chk("errrun_digest", digest, 64'h1);

        // Following fill clears the error and succeeds
        run4(-1, 0, -1, -1, -1, dc, nw);
        chk("recover_done_cycle", 64'(dc), 64'd9);
        chk("recover_nwr", 64'(nw), 64'd4);
        chk("recover_err", 64'(err), 64'd0);
        chk("recover_digest", digest, 64'hF);

        // Start pulsed again mid-fill is ignored
        run4(-1, 0, -1, 4, -1, dc, nw);
        chk("restart_done_cycle", 64'(dc), 64'd9);
        chk("restart_nwr", 64'(nw), 64'd4);
        chk("restart_digest", digest, 64'hF);

        // Reset at cycle 5 of a fill
        run4(-1, 0, -1, -1, 5, dc, nw);
        chk("rstrun_nwr", 64'(nw), 64'd2);
        chk("rstrun_no_done", 64'(dc), -64'sd1);
        chk("rstrun_busy", 64'(busy), 64'd0);
        chk("rstrun_digest", digest, 64'd0);

        // Depth=1, BaseAddr=0xFFFF
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("d1_req", 64'(s_req), 64'd1);
        chk("d1_addr", 64'(s_addr), 64'hFFFF);
        s_gnt = 1'b1;
        @(negedge clk);
        s_gnt    = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 64'hDEADBEEF_00000001;
        @(negedge clk);
        s_rvalid = 1'b0;
        s_rdata  = '0;
        chk("d1_done", 64'(s_done), 64'd1);
        chk("d1_wr_en", 64'(s_wr_en), 64'd1);
        chk("d1_wr_addr", 64'(s_wr_addr), 64'd0);
        chk("d1_wr_data", s_wr_data, 64'hDEADBEEF_00000001);
        chk("d1_digest", s_digest, 64'hDEADBEEF_00000001);
        @(negedge clk);
        chk("d1_idle", 64'(s_busy), 64'd0);
        chk("d1_wr_en_off", 64'(s_wr_en), 64'd0);
        chk("d1_digest_hold", s_digest, 64'hDEADBEEF_00000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
